// File: rtl/ram_burst_master.sv
// ram_burst_master
//
// Burst initiator for the single-port 16x16 data RAM. It takes one read or write burst command
// over a valid/ready handshake. It sequences the RAM enables, address and write data one beat
// at a time. Write data arrives and read data leaves on their own valid/ready streams. This
// block is the only driver of the RAM ports.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-high reset; aborts any burst in flight
//   i_cmd_valid  command present
//   o_cmd_ready  command accepted when i_cmd_valid && o_cmd_ready (high only in idle)
//   i_cmd_write  1 = write burst, 0 = read burst
//   i_cmd_addr   burst start address
//   i_cmd_len    beats minus one (0 -> 1 beat, 2^ADSize-1 -> 2^ADSize beats)
//   i_wr_valid   write beat present
//   o_wr_ready   write beat consumed when i_wr_valid && o_wr_ready
//   i_wr_data    write beat data
//   o_rd_valid   read beat present
//   i_rd_ready   read beat consumed when o_rd_valid && i_rd_ready
//   o_rd_data    registered read beat data, stable while o_rd_valid waits for i_rd_ready
//   o_busy       high whenever the FSM is not idle
//   o_done       one-cycle pulse after the last beat of a burst completes
//   o_en_write   RAM write enable
//   o_en_read    RAM read enable
//   o_addr       RAM address (registered beat address)
//   o_dmin       RAM write data
//   i_dmout      RAM read data, valid the cycle after o_en_read
//
// Beat address increments modulo 2^ADSize, so a burst may wrap from the top of the RAM to 0.
// A read beat takes at least three cycles: issue, wait for the RAM, present to the consumer.

module ram_burst_master #(
    parameter int unsigned ADSize = 4,
    parameter int unsigned DASize = 16
) (
    input  logic              clk,
    input  logic              rst,
    // command channel
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADSize-1:0] i_cmd_addr,
    input  logic [ADSize-1:0] i_cmd_len,
    // write data stream
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DASize-1:0] i_wr_data,
    // read data stream
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DASize-1:0] o_rd_data,
    // status
    output logic              o_busy,
    output logic              o_done,
    // RAM side
    output logic              o_en_write,
    output logic              o_en_read,
    output logic [ADSize-1:0] o_addr,
    output logic [DASize-1:0] o_dmin,
    input  logic [DASize-1:0] i_dmout
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWr      = 3'd1,
        StRdIssue = 3'd2,
        StRdWait  = 3'd3,
        StRdOut   = 3'd4,
        StDone    = 3'd5
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [ADSize-1:0]   r_addr;
    logic [ADSize-1:0]   w_addr_next;
    logic [ADSize-1:0]   r_cnt;
    logic [ADSize-1:0]   w_cnt_next;
    logic [DASize-1:0]   r_rd_data;
    logic [DASize-1:0]   w_rd_data_next;

    // ------------------------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= w_addr_next;
            r_cnt     <= w_cnt_next;
            r_rd_data <= w_rd_data_next;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_cnt_next     = r_cnt;
        w_rd_data_next = r_rd_data;

        unique case (r_state)
            StIdle: begin
                // The command is only sampled here. A command offered while busy is not queued.
                if (i_cmd_valid) begin
                    w_addr_next  = i_cmd_addr;
                    w_cnt_next   = i_cmd_len;
                    w_state_next = i_cmd_write ? StWr : StRdIssue;
                end
            end

            StWr: begin
                if (i_wr_valid) begin
                    if (r_cnt == '0) begin
                        w_state_next = StDone;
                    end else begin
                        w_cnt_next  = r_cnt - ADSize'(1);
                        w_addr_next = r_addr + ADSize'(1);
                    end
                end
            end

            StRdIssue: begin
                w_state_next = StRdWait;
            end

            StRdWait: begin
                // The RAM presents data one cycle after the enable. Capture it here so the
                // consumer sees a stable value for as long as it stalls.
                w_rd_data_next = i_dmout;
                w_state_next   = StRdOut;
            end

            StRdOut: begin
                if (i_rd_ready) begin
                    if (r_cnt == '0) begin
                        w_state_next = StDone;
                    end else begin
                        w_cnt_next   = r_cnt - ADSize'(1);
                        w_addr_next  = r_addr + ADSize'(1);
                        w_state_next = StRdIssue;
                    end
                end
            end

            StDone: begin
                w_state_next = StIdle;
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------------------------
    always_comb begin
        o_cmd_ready = 1'b0;
        o_wr_ready  = 1'b0;
        o_rd_valid  = 1'b0;
        o_done      = 1'b0;
        o_en_write  = 1'b0;
        o_en_read   = 1'b0;

        unique case (r_state)
            StIdle:    o_cmd_ready = 1'b1;
            StWr: begin
                o_wr_ready = 1'b1;
                // The write happens in the same cycle as the handshake, so a stalled source
                // writes nothing.
                o_en_write = i_wr_valid;
            end
            StRdIssue: o_en_read  = 1'b1;
            StRdWait:  o_en_read  = 1'b0;
            StRdOut:   o_rd_valid = 1'b1;
            StDone:    o_done     = 1'b1;
            default:   o_cmd_ready = 1'b0;
        endcase
    end

    assign o_busy    = (r_state != StIdle);
    assign o_addr    = r_addr;
    assign o_dmin    = i_wr_data;
    assign o_rd_data = r_rd_data;

`ifndef SYNTHESIS
    // The RAM has a single port and cannot read and write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(o_en_read && o_en_write));
        end
    end
`endif

endmodule
